// File: rtl/regfile_wb_pkg.sv
// Shared pipeline constants and types for the write-back stage and register file.
package regfile_wb_pkg;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 5;
    localparam int NUM_REGS     = 2 ** ADDR_W;
    localparam int NUM_RD_PORTS = 2;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] rn_t;
    typedef logic [NUM_REGS-1:0][DATA_W-1:0] regs_t;

    // What is being committed this cycle; en already folds in clr and the zero-index rule.
    typedef struct packed {
        logic  en;
        rn_t   rn;
        word_t data;
    } wb_commit_t;

    function automatic word_t wb_select(input logic m2reg, input word_t mo, input word_t alu);
        return m2reg ? mo : alu;
    endfunction
endpackage

// File: rtl/regfile_wb_if.sv
// MEM/WB write-back inputs, decode read ports and forwarding output as one bundle.
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic  wwreg;
    logic  wm2reg;
    word_t walu;
    word_t wmo;
    rn_t   wrn;
    rn_t   rna;
    rn_t   rnb;
    word_t qa;
    word_t qb;
    word_t wdi;

    modport master (
        output wwreg, wm2reg, walu, wmo, wrn, rna, rnb,
        input  qa, qb, wdi
    );

    modport slave (
        input  wwreg, wm2reg, walu, wmo, wrn, rna, rnb,
        output qa, qb, wdi
    );
endinterface

// File: rtl/regfile_wb_rf_read_port.sv
// One combinational register-file read port with write-to-read bypass.
module rf_read_port
    import regfile_wb_pkg::*;
(
    input  rn_t        i_rn,
    input  regs_t      i_regs,
    input  wb_commit_t i_commit,
    output word_t      o_q
);
    // Zero index wins over bypass so r0 reads 0 even while being "written".
    always_comb begin
        o_q = i_regs[i_rn];
        if (i_rn == REG_ZERO)
            o_q = '0;
        else if (i_commit.en && (i_commit.rn == i_rn))
            o_q = i_commit.data;
    end
endmodule

// File: rtl/regfile_wb.sv
// Write-back data select plus 32x32 architectural register file with bypassed reads.
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic         clk,
    input  logic         clr,
    regfile_wb_if.slave  bus
);
    regs_t      r_regs;
    word_t      w_wdi;
    wb_commit_t w_commit;
    rn_t   [NUM_RD_PORTS-1:0] w_rn;
    word_t [NUM_RD_PORTS-1:0] w_q;

    assign w_wdi = wb_select(bus.wm2reg, bus.wmo, bus.walu);

    // clr suppresses both the commit and the bypass through the same enable.
    assign w_commit.en   = bus.wwreg && (bus.wrn != REG_ZERO) && !clr;
    assign w_commit.rn   = bus.wrn;
    assign w_commit.data = w_wdi;

    always_ff @(posedge clk) begin
        if (clr)
            r_regs <= '0;
        else if (w_commit.en)
            r_regs[w_commit.rn] <= w_commit.data;
    end

    assign w_rn[0] = bus.rna;
    assign w_rn[1] = bus.rnb;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        rf_read_port u_rd (
            .i_rn     (w_rn[p]),
            .i_regs   (r_regs),
            .i_commit (w_commit),
            .o_q      (w_q[p])
        );
    end

    assign bus.qa  = w_q[0];
    assign bus.qb  = w_q[1];
    assign bus.wdi = w_wdi;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, ALU/load write-back, r0, bypass and reset gating.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_pass;

    regfile_wb_if rf_if ();

    regfile_wb dut (
        .clk (clk),
        .clr (clr),
        .bus (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.wwreg  = 1'b0;
        rf_if.wm2reg = 1'b0;
        rf_if.walu   = '0;
        rf_if.wmo    = '0;
        rf_if.wrn    = '0;
    endtask

    task automatic preload(input rn_t rn, input word_t val);
        rf_if.wwreg  = 1'b1;
        rf_if.wm2reg = 1'b0;
        rf_if.walu   = val;
        rf_if.wrn    = rn;
        tick();
        idle();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        rf_if.wwreg  = 1'b1;
        rf_if.wm2reg = 1'b0;
        rf_if.wrn    = 5'd5;
        rf_if.walu   = 32'hDEADBEEF;
        tick();
        clr = 1'b0;
        idle();
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_if.rna = rn_t'(i);
            rf_if.rnb = rn_t'(NUM_REGS - 1 - i);
            #1;
            n_checks++;
            if (rf_if.qa !== 32'h0)
                $display("FAIL reset_qa[%0d] got=%h exp=%h", i, rf_if.qa, 32'h0);
            else n_pass++;
            n_checks++;
            if (rf_if.qb !== 32'h0)
                $display("FAIL reset_qb[%0d] got=%h exp=%h", NUM_REGS - 1 - i, rf_if.qb, 32'h0);
            else n_pass++;
        end
    endtask

    task automatic test_alu_write();
        rf_if.wwreg  = 1'b1;
        rf_if.wm2reg = 1'b0;
        rf_if.wrn    = 5'd3;
        rf_if.walu   = 32'h12345678;
        rf_if.wmo    = 32'h0BADF00D;
        rf_if.rna    = 5'd3;
        rf_if.rnb    = 5'd2;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h12345678) $display("FAIL alu_bypass_qa got=%h exp=%h", rf_if.qa, 32'h12345678);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'h0) $display("FAIL alu_other_qb got=%h exp=%h", rf_if.qb, 32'h0);
        else n_pass++;
        n_checks++;
        if (rf_if.wdi !== 32'h12345678) $display("FAIL alu_wdi got=%h exp=%h", rf_if.wdi, 32'h12345678);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h12345678) $display("FAIL alu_stored_qa got=%h exp=%h", rf_if.qa, 32'h12345678);
        else n_pass++;
    endtask

    task automatic test_load_write();
        rf_if.wwreg  = 1'b1;
        rf_if.wm2reg = 1'b1;
        rf_if.wmo    = 32'hCAFEF00D;
        rf_if.walu   = 32'h11111111;
        rf_if.wrn    = 5'd7;
        rf_if.rna    = 5'd7;
        rf_if.rnb    = 5'd7;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hCAFEF00D) $display("FAIL load_bypass_qa got=%h exp=%h", rf_if.qa, 32'hCAFEF00D);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'hCAFEF00D) $display("FAIL load_bypass_qb got=%h exp=%h", rf_if.qb, 32'hCAFEF00D);
        else n_pass++;
        n_checks++;
        if (rf_if.wdi !== 32'hCAFEF00D) $display("FAIL load_wdi got=%h exp=%h", rf_if.wdi, 32'hCAFEF00D);
        else n_pass++;
        tick();
        rf_if.wwreg  = 1'b0;
        rf_if.wm2reg = 1'b0;
        #1;
        n_checks++;
        if (rf_if.wdi !== 32'h11111111) $display("FAIL load_wdi_alu got=%h exp=%h", rf_if.wdi, 32'h11111111);
        else n_pass++;
        n_checks++;
        if (rf_if.qa !== 32'hCAFEF00D) $display("FAIL load_stored_qa got=%h exp=%h", rf_if.qa, 32'hCAFEF00D);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'hCAFEF00D) $display("FAIL load_stored_qb got=%h exp=%h", rf_if.qb, 32'hCAFEF00D);
        else n_pass++;
        idle();
    endtask

    task automatic test_zero_reg();
        rf_if.wwreg  = 1'b1;
        rf_if.wm2reg = 1'b0;
        rf_if.wrn    = 5'd0;
        rf_if.walu   = 32'hFFFFFFFF;
        rf_if.rna    = 5'd0;
        rf_if.rnb    = 5'd0;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h0) $display("FAIL zero_bypass_qa got=%h exp=%h", rf_if.qa, 32'h0);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'h0) $display("FAIL zero_bypass_qb got=%h exp=%h", rf_if.qb, 32'h0);
        else n_pass++;
        n_checks++;
        if (rf_if.wdi !== 32'hFFFFFFFF) $display("FAIL zero_wdi got=%h exp=%h", rf_if.wdi, 32'hFFFFFFFF);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h0) $display("FAIL zero_stored_qa got=%h exp=%h", rf_if.qa, 32'h0);
        else n_pass++;
    endtask

    task automatic test_write_disabled();
        preload(5'd9, 32'hAAAA0000);
        rf_if.wwreg = 1'b0;
        rf_if.wrn   = 5'd9;
        rf_if.walu  = 32'h00005555;
        rf_if.rna   = 5'd9;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hAAAA0000) $display("FAIL wdis_same_qa got=%h exp=%h", rf_if.qa, 32'hAAAA0000);
        else n_pass++;
        n_checks++;
        if (rf_if.wdi !== 32'h00005555) $display("FAIL wdis_wdi got=%h exp=%h", rf_if.wdi, 32'h00005555);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hAAAA0000) $display("FAIL wdis_after_qa got=%h exp=%h", rf_if.qa, 32'hAAAA0000);
        else n_pass++;
        idle();
    endtask

    task automatic test_reset_bypass();
        preload(5'd4, 32'h00000001);
        clr = 1'b1;
        rf_if.wwreg = 1'b1;
        rf_if.wrn   = 5'd4;
        rf_if.walu  = 32'h00000002;
        rf_if.rna   = 5'd4;
        rf_if.rnb   = 5'd9;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h00000001) $display("FAIL rstbyp_during_qa got=%h exp=%h", rf_if.qa, 32'h00000001);
        else n_pass++;
        n_checks++;
        if (rf_if.wdi !== 32'h00000002) $display("FAIL rstbyp_wdi got=%h exp=%h", rf_if.wdi, 32'h00000002);
        else n_pass++;
        tick();
        clr = 1'b0;
        idle();
        #1;
        n_checks++;
        if (rf_if.qa !== 32'h0) $display("FAIL rstbyp_after_qa got=%h exp=%h", rf_if.qa, 32'h0);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'h0) $display("FAIL rstbyp_after_qb9 got=%h exp=%h", rf_if.qb, 32'h0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rf_if.wwreg = 1'b1;
        rf_if.wrn   = 5'd10;
        rf_if.walu  = 32'hA0A0A0A0;
        tick();
        rf_if.wrn  = 5'd11;
        rf_if.walu = 32'hB1B1B1B1;
        rf_if.rna  = 5'd10;
        rf_if.rnb  = 5'd11;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hA0A0A0A0) $display("FAIL b2b_stored_qa got=%h exp=%h", rf_if.qa, 32'hA0A0A0A0);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'hB1B1B1B1) $display("FAIL b2b_bypass_qb got=%h exp=%h", rf_if.qb, 32'hB1B1B1B1);
        else n_pass++;
        tick();
        // Overwrite r10: bypass must take precedence over the stored value.
        rf_if.wrn  = 5'd10;
        rf_if.walu = 32'hC2C2C2C2;
        rf_if.rna  = 5'd11;
        rf_if.rnb  = 5'd10;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hB1B1B1B1) $display("FAIL b2b_stored_qa11 got=%h exp=%h", rf_if.qa, 32'hB1B1B1B1);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'hC2C2C2C2) $display("FAIL b2b_overwrite_qb got=%h exp=%h", rf_if.qb, 32'hC2C2C2C2);
        else n_pass++;
        tick();
        idle();
        rf_if.rna = 5'd10;
        rf_if.rnb = 5'd31;
        #1;
        n_checks++;
        if (rf_if.qa !== 32'hC2C2C2C2) $display("FAIL b2b_final_qa got=%h exp=%h", rf_if.qa, 32'hC2C2C2C2);
        else n_pass++;
        n_checks++;
        if (rf_if.qb !== 32'h0) $display("FAIL b2b_r31_qb got=%h exp=%h", rf_if.qb, 32'h0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clr      = 1'b0;
        idle();
        rf_if.rna = '0;
        rf_if.rnb = '0;
        #2;
        test_reset();
        test_alu_write();
        test_load_write();
        test_zero_reg();
        test_write_disabled();
        test_reset_bypass();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb.md
# regfile_wb

Write-back stage and architectural register file of the five-stage pipeline. Consumes the MEM/WB pipeline register outputs, selects load data or ALU result as write-back data, and commits it to a 32×32 register file on the clock edge. Serves the decode stage through two combinational read ports, with same-cycle write-to-read bypass so a decode read never sees a stale value.

## Interface
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2^ADDR_W registers)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset: synchronous, active-high
- wwreg  in  1  write-enable from MEM/WB
- wm2reg  in  1  1 = write load data (wmo), 0 = write ALU result (walu)
- walu  in  DATA_W  ALU result from MEM/WB
- wmo  in  DATA_W  memory load data from MEM/WB
- wrn  in  ADDR_W  destination register index
- rna  in  ADDR_W  decode read port A index
- rnb  in  ADDR_W  decode read port B index
- qa  out  DATA_W  read data port A
- qb  out  DATA_W  read data port B
- wdi  out  DATA_W  selected write-back data (to EX forwarding muxes)

## Operation
- wdi = wm2reg ? wmo : walu; purely combinational, independent of wwreg and clr.
- Commit condition: wwreg=1, wrn≠0, clr=0 → regs[wrn] ← wdi at rising clk.
- Register 0 hard-wired zero: writes to index 0 discarded; reads of index 0 return 0 regardless of bypass.
- Read port X (A/B, identical logic):
  - rnX=0 → 0
  - else if commit condition true and wrn=rnX → wdi (bypass)
  - else → regs[rnX]
- Bypass gated by clr: during a reset cycle, reads return stored contents, never wdi.
- Both ports may address the same register, including the write target; both bypass simultaneously.
- No read/write ordering hazard: write-then-read within one cycle resolved by bypass; stored value updated at edge.

## Timing
- Reset: clr=1 at rising edge → all registers 0 after that edge; any concurrent write is dropped. clr asserted mid-stream wipes state regardless of pending wwreg.
- Write latency: committed value visible in regs one edge after presentation; visible on qa/qb in the same cycle via bypass.
- Read latency: zero (combinational from rnX, regs, and write-back inputs).
- wdi: zero latency from walu/wmo/wm2reg.
- No handshake; stage never stalls. Upstream holds MEM/WB values for exactly one cycle per instruction.
- Outputs have no registered reset value; after reset with no write pending, qa=qb=0 for every index.

## Structure
- Shared pipeline package: DATA_W, ADDR_W, REG_ZERO index constant, NUM_REGS = 2^ADDR_W.
- Sub-module: rf_read_port (one index in; regs array, write-back controls in; data out), instantiated twice for A and B so bypass logic is written once.
- Storage: flop array with synchronous clear; no RAM macro (reset-to-zero required).

## Test plan
- Reset: clr=1 for one edge with wwreg=1, wrn=5, walu=0xDEADBEEF → after edge all rna/rnb in 0..31 read 0; reg 5 is 0.
- ALU write then read: wwreg=1, wm2reg=0, wrn=3, walu=0x12345678, rna=3 → qa=0x12345678 same cycle (bypass), and next cycle with wwreg=0 still 0x12345678.
- Load write: wm2reg=1, wmo=0xCAFEF00D, walu=0x11111111, wrn=7, rna=rnb=7 → qa=qb=wdi=0xCAFEF00D; reg 7 holds 0xCAFEF00D after edge.
- Zero register: wwreg=1, wrn=0, walu=0xFFFFFFFF, rna=0 → qa=0 same cycle and after edge; wdi=0xFFFFFFFF.
- Write disabled: preload reg 9=0xAAAA0000; wwreg=0, wrn=9, walu=0x5555 → qa(rna=9)=0xAAAA0000 same cycle and after edge.
- Reset with bypass match: reg 4=0x1; clr=1, wwreg=1, wrn=4, walu=0x2, rna=4 → qa=0x1 during cycle, 0 after edge.
